// File: rtl/rf_pkg.sv
// Shared types and defaults for the reg_file_bank register file and its scoreboard.
package rf_pkg;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREGS_DEF = 32;
  localparam int REG_ZERO     = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Bit 0 (x0) never reports busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int  NREGS = RF_NREGS_DEF,
  parameter int  NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_all_i,
  input  logic                set_en_i,
  input  logic [AW-1:0]       set_idx_i,
  input  logic                clr_en_i,
  input  logic [AW-1:0]       clr_idx_i,
  input  logic [NREAD*AW-1:0] raddr_i,
  output logic [NREAD-1:0]    busy_o
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;

  // The set is applied after the clear: a same-register issue belongs to a younger producer.
  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_idx_i] = 1'b0;
    if (set_en_i) sb_d[set_idx_i] = 1'b1;
    sb_d[REG_ZERO] = 1'b0;
    if (clr_all_i) sb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) sb_q <= '0;
    else      sb_q <= sb_d;
  end

  always_comb begin
    busy_o = '0;
    for (int k = 0; k < NREAD; k++) begin
      busy_o[k] = sb_q[raddr_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_bank.sv
// Integer register file with combinational reads, one write port, a pending-write
// scoreboard and a one-register-per-cycle clear sweep. Optional macro: REGFILE_BYPASS_EN.
module reg_file_bank
  import rf_pkg::*;
#(
  parameter int  XLEN  = RF_XLEN_DEF,
  parameter int  NREGS = RF_NREGS_DEF,
  parameter int  NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wd,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  mem_q [NREGS];
  logic             in_ready;
  logic             accept;
  logic             wr_fire;
  logic [NREAD-1:0] sb_busy;

  assign in_ready = (state_q == RF_READY);
  assign ready    = in_ready;
  // Reset beats clr_req, which beats any write or issue in the same cycle.
  assign accept   = rst && in_ready && !clr_req;
  assign wr_fire  = accept && we && (waddr != ZERO_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr_req) begin
      state_d = RF_CLEAR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          if (cnt_q == LAST_IDX) state_d = RF_READY;
          else                   cnt_d   = cnt_q + AW'(1);
        end
        RF_READY: ;
        default:  state_d = RF_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The array itself has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) mem_q[cnt_q] <= '0;
    else if (wr_fire)        mem_q[waddr] <= wd;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clr_all_i (clr_req),
    .set_en_i  (accept && iss_valid),
    .set_idx_i (iss_rd),
    .clr_en_i  (accept && we),
    .clr_idx_i (waddr),
    .raddr_i   (raddr),
    .busy_o    (sb_busy)
  );

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (raddr[k*AW +: AW] != ZERO_IDX) rdata[k*XLEN +: XLEN] = mem_q[raddr[k*AW +: AW]];
      rbusy[k] = in_ready && sb_busy[k];
`ifdef REGFILE_BYPASS_EN
      if (in_ready && we && (waddr != ZERO_IDX) && (raddr[k*AW +: AW] == waddr)) begin
        rdata[k*XLEN +: XLEN] = wd;
        rbusy[k]              = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench for reg_file_bank: directed vector table, clear/reset sequences,
// and randomized traffic checked against an array-based reference model.
module tb_reg_file_bank;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clr_req;
  logic                  ready;
  logic [NREAD*AW-1:0]   raddr;
  logic [NREAD*XLEN-1:0] rdata;
  logic [NREAD-1:0]      rbusy;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [XLEN-1:0]       wd;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;

  int tests = 0;
  int fails = 0;

  // Reference model: register contents, which entries are known, busy flags, sweep progress.
  logic [XLEN-1:0] m_mem   [NREGS];
  bit              m_valid [NREGS];
  bit              m_busy  [NREGS];
  int              sweep_left = 0;
  int              sweep_pos  = 0;

  typedef struct {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wd;
    logic            iss;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] exp_rd;
    logic            exp_busy;
  } vec_t;

  vec_t vecs [15];

  reg_file_bank #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .ready     (ready),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we        (we),
    .waddr     (waddr),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit was_ready;
    was_ready = (sweep_left == 0);
    if (sweep_left > 0) begin
      m_mem[sweep_pos]   = '0;
      m_valid[sweep_pos] = 1'b1;
    end
    if (!rst || clr_req) begin
      sweep_left = NREGS;
      sweep_pos  = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else if (was_ready) begin
      if (we && waddr != 0) begin
        m_mem[waddr]   = wd;
        m_valid[waddr] = 1'b1;
      end
      if (we)        m_busy[waddr]  = 1'b0;
      if (iss_valid) m_busy[iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
    end else begin
      sweep_pos++;
      sweep_left--;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req   = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    wd        = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  task automatic check_model();
    logic [AW-1:0]   a;
    logic [XLEN-1:0] e;
    bit              v;
    bit              b;
    #1;
    chk("model_ready", {63'd0, ready}, {63'd0, (sweep_left == 0)});
    for (int k = 0; k < NREAD; k++) begin
      a = raddr[k*AW +: AW];
      e = (a == 0) ? '0 : m_mem[a];
      v = (a == 0) || m_valid[a];
      b = (sweep_left == 0) ? m_busy[a] : 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (sweep_left == 0 && we && waddr != 0 && a == waddr) begin
        e = wd;
        v = 1'b1;
        b = 1'b0;
      end
`endif
      if (v) chk("model_rdata", {32'd0, rdata[k*XLEN +: XLEN]}, {32'd0, e});
      chk("model_rbusy", {63'd0, rbusy[k]}, {63'd0, b});
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      cycle();
      n++;
    end
    chk(name, 64'(n), 64'(NREGS));
  endtask

  initial begin
    int n;
    rst   = 1'b0;
    raddr = '0;
    idle_inputs();
    foreach (m_valid[i]) begin
      m_valid[i] = 1'b0;
      m_busy[i]  = 1'b0;
      m_mem[i]   = '0;
    end

    // Reset then idle: ready low for the whole sweep, everything reads zero afterwards.
    cycle();
    cycle();
    rst = 1'b1;
    chk("reset_ready_low", {63'd0, ready}, 64'd0);
    wait_ready("reset_sweep_len");
    for (int r = 0; r < NREGS; r++) begin
      raddr = {5'(NREGS - 1 - r), 5'(r)};
      #1;
      chk("reset_read", rdata, 64'd0);
      chk("reset_busy", {62'd0, rbusy}, 64'd0);
    end

    // Directed vectors: inputs for one cycle, expected port-0 view during that cycle.
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 5'd7, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h77,       1'b0};
    vecs[8]  = '{1'b1, 5'd7, 32'h88,       1'b1, 5'd7, 5'd7, 32'h77,       1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h88,       1'b1};
    vecs[10] = '{1'b1, 5'd7, 32'h99,       1'b1, 5'd9, 5'd7, 32'h88,       1'b1};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h99,       1'b0};
    vecs[13] = '{1'b1, 5'd9, 32'h1,        1'b0, 5'd0, 5'd9, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd9, 32'h1,        1'b0};
    foreach (vecs[i]) begin
      we        = vecs[i].we;
      waddr     = vecs[i].waddr;
      wd        = vecs[i].wd;
      iss_valid = vecs[i].iss;
      iss_rd    = vecs[i].iss_rd;
      raddr     = {5'd0, vecs[i].ra};
      #1;
      chk($sformatf("vec%0d_rdata", i), {32'd0, rdata[XLEN-1:0]}, {32'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_rbusy", i), {63'd0, rbusy[0]}, {63'd0, vecs[i].exp_busy});
      chk($sformatf("vec%0d_x0port", i), {32'd0, rdata[2*XLEN-1:XLEN]}, 64'd0);
      cycle();
    end
    idle_inputs();

    // Clear request: sweep wipes x3, and a write to x4 during the sweep is dropped.
    we = 1'b1; waddr = 5'd3; wd = 32'hA5A5A5A5;
    cycle();
    idle_inputs();
    raddr = {5'd4, 5'd3};
    #1;
    chk("clr_pre_x3", {32'd0, rdata[XLEN-1:0]}, 64'hA5A5A5A5);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      we = (n == 5); waddr = 5'd4; wd = 32'd1;
      cycle();
      n++;
    end
    idle_inputs();
    chk("clr_sweep_len", 64'(n), 64'(NREGS));
    #1;
    chk("clr_post_x3", {32'd0, rdata[XLEN-1:0]}, 64'd0);
    chk("clr_post_x4", {32'd0, rdata[2*XLEN-1:XLEN]}, 64'd0);

    // Reset while the sweep is at count 10 restarts it from zero.
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (10) cycle();
    chk("midreset_ready_low", {63'd0, ready}, 64'd0);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wait_ready("midreset_sweep_len");

    // Randomized traffic against the model, with occasional clear requests.
    for (int i = 0; i < 800; i++) begin
      we        = 1'($urandom_range(0, 1));
      waddr     = 5'($urandom_range(0, 7));
      wd        = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      raddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      clr_req   = ($urandom_range(0, 149) == 0);
      check_model();
      cycle();
    end
    idle_inputs();
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
